imem_dmem_arbiter: RTL
======================

# imem_dmem_arbiter

Shares one single-ported unified memory between the pipelined CPU's instruction-fetch stage (IF) and its memory-access stage (MEM). Each stage holds a request level-high and sees a stall until its access completes. The block serialises the accesses with fixed priority to MEM and drives a request/ready handshake toward the memory. A watchdog aborts accesses the memory never acknowledges and flags a sticky error.

## Interface
- ADDR_W, 32, byte-address width of both requesters and memory
- DATA_W, 32, data word width
- TIMEOUT, 15, max cycles in a BUSY state before abort (≥1)
- Clock  in  1  rising-edge clock
- Reset_n  in  1  reset; one clock; synchronous, active-low
- if_req  in  1  fetch request (level, held until stall low)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  instruction word; valid only in fetch completion cycle, else 0
- if_stall  out  1  fetch not completing this cycle
- d_req  in  1  data request (level, held until stall low)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load word; valid only in data completion cycle, else 0
- d_stall  out  1  data access not completing this cycle
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory acknowledge, one-cycle pulse
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: d_req=1 -> BUSY_D; latch d_addr, d_we, d_wdata into mem_*; mem_req=1. Else if_req=1 -> BUSY_I; latch if_addr; mem_we=0. Else stay.
- BUSY_x: hold mem_* stable. mem_ready=1 -> IDLE; mem_req, mem_we drop to 0; completion cycle for x.
- Completion cycle: x_stall=0 and x_rdata=mem_rdata, both combinational from mem_ready. For stores, d_rdata=0.
- x_stall = x_req & ~(state==BUSY_x & mem_ready). With x_req=0, stall is 0.
- Watchdog: 4-bit-min counter, cleared on entry to BUSY_*, increments each BUSY cycle without mem_ready. Reaching TIMEOUT -> IDLE, mem_req=0, err<=1. Requester stays stalled and is re-arbitrated normally.
- mem_ready in IDLE is ignored.
- A requester dropping req while BUSY for it does not abort. The access finishes and its completion is discarded.

## Timing
- Reset (Reset_n=0 at edge): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, err=0.
- If_rdata and d_rdata are 0 outside completion.
- Reset mid-access abandons the access with no completion. Stalls during reset follow the req inputs.
- Minimum access: request seen in cycle N, mem_req high from N+1, mem_ready earliest N+1, completion in N+1. This gives 1 stall cycle.
- Each completion returns to IDLE, so back-to-back accesses take ≥2 cycles each.
- Simultaneous if_req and d_req in IDLE: data wins; fetch is served after data completes.
- Timeout: the abort occurs at the edge ending the TIMEOUT-th BUSY cycle without mem_ready.
- mem_ready coinciding with the timeout edge counts as completion; err stays unchanged.

## Structure
- Shared package cpu_pkg:
  - state enum arb_state_t {IDLE, BUSY_I, BUSY_D};
  - defaults for ADDR_W and DATA_W.
- No sub-module needed. The watchdog counter stays inline.
- The single-ported memory model for the bench is separate and not part of this block.

## Test plan
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x0; memory returns 0x8c030000 with mem_ready 1 cycle after mem_req.
  - Response: if_stall high 1 cycle, then low with if_rdata=0x8c030000; mem_we=0.
- Collision:
  - Stimulus: if_req=d_req=1 in IDLE, d_addr=0x8, d_we=0; load returns 0xFFFFFFFF.
  - Response: BUSY_D first, d_rdata=0xFFFFFFFF; then BUSY_I; the fetch completes ≥2 cycles later.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x18, d_wdata=0x9.
  - Response: mem_we=1, mem_addr=0x18, mem_wdata=0x9 held until mem_ready; d_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=15 and mem_ready never asserted.
  - Response: mem_req drops after 15 BUSY cycles, err=1 and stays 1, and the stall persists.
  - Then mem_ready returns: the retried access completes and err is still 1.
- Reset mid-access:
  - Stimulus: Reset_n=0 for one edge while in BUSY_D.
  - Response: IDLE, mem_req=0, err=0, no completion pulse. The held d_req re-arbitrates after reset.
- Spurious mem_ready in IDLE:
  - Response: no completion on either port and no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and default widths for the instruction/data memory arbiter.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the unified memory.
// The master modport is the arbiter's view; slave is the surrounding CPU/memory view.
interface imem_dmem_arbiter_if #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEF
);
    // fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    // memory-access stage
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    // unified memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  err
    );

endinterface

// File: rtl/imem_dmem_arbiter.sv
// Serialises IF and MEM stage accesses onto one single-ported memory, MEM first,
// with a watchdog that aborts unacknowledged accesses and raises a sticky error.
module imem_dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                  Clock,
    input logic                  Reset_n,
    imem_dmem_arbiter_if.master  bus
);

    // At least 4 bits; wider only when TIMEOUT needs it.
    localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic              done_i_c;
    logic              done_d_c;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // Arbitration, memory handshake and watchdog.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    state_d     = BUSY_D;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d    = BUSY_I;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                end
            end
            BUSY_I, BUSY_D: begin
                // A late acknowledge on the timeout edge still counts as completion.
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Completion is only recognised out of reset, while busy for that requester.
    assign done_i_c = Reset_n & (state_q == BUSY_I) & bus.mem_ready;
    assign done_d_c = Reset_n & (state_q == BUSY_D) & bus.mem_ready;

    assign bus.if_stall  = bus.if_req & ~done_i_c;
    assign bus.d_stall   = bus.d_req & ~done_d_c;
    assign bus.if_rdata  = done_i_c ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (done_d_c & ~mem_we_q) ? bus.mem_rdata : '0;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;

endmodule
